// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency imem, delivers inst/PC via a
// 2-entry valid/ready buffer. Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt_req,
    output logic                halted,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_squashed
);

    typedef enum logic [1:0] {StBoot, StRun, StHalting, StHalted} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [31:0]         inst_q [2];
    logic [31:0]         inst_d [2];
    logic [PC_WIDTH-1:0] pc_q [2];
    logic [PC_WIDTH-1:0] pc_d [2];
    logic [1:0]          count_q, count_d;

    logic       pop, issue, push;
    logic [1:0] occupancy, wr_idx;

    assign out_valid = (count_q != 2'd0);
    assign out_inst  = inst_q[0];
    assign out_pc    = pc_q[0];
    assign halted    = (state_q == StHalted);
    assign pop       = out_valid & out_ready;
    assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;
    // Entries that will still be held after this cycle, before any new issue.
    assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    // A redirect squashes the word returning this cycle.
    assign push      = inflight_q & ~redirect_valid;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            StBoot:    state_d = halt_req ? StHalting : StRun;
            StRun: begin
                if (halt_req) begin
                    state_d = StHalting;
                end else begin
                    issue = redirect_valid || (occupancy <= 2'd1);
                end
            end
            StHalting: if (!inflight_q) state_d = StHalted;
            StHalted:  if (!halt_req) state_d = StRun;
            default:   state_d = StBoot;
        endcase
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            fetch_pc_d    = imem_addr + PC_STEP;
            inflight_pc_d = imem_addr;
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        count_d = count_q;
        wr_idx  = pop ? count_q - 2'd1 : count_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                inst_d[0] = inst_q[1];
                pc_d[0]   = pc_q[1];
            end
            if (push) begin
                inst_d[wr_idx[0]] = imem_rdata;
                pc_d[wr_idx[0]]   = inflight_pc_q;
            end
            count_d = wr_idx + {1'b0, push};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            inst_q[0]     <= '0;
            inst_q[1]     <= '0;
            pc_q[0]       <= '0;
            pc_q[1]       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, squashed_q, discarded;

    // The entry popped in a redirect cycle is delivered, not discarded.
    assign discarded = 32'(count_q) - 32'(pop) + 32'(inflight_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q  <= '0;
            squashed_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(pop);
            if (redirect_valid) squashed_q <= squashed_q + discarded;
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_squashed = squashed_q;
`else
    assign perf_fetched  = '0;
    assign perf_squashed = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the imem model returns 0xA0000000 | addr one cycle late.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= 32'hA000_0000 | imem_addr;

    always @(negedge clk) begin
        if (rst_n && dut.count_q == 2'd3) begin
            errors++;
            $error("FAIL buffer_overflow observed count=3 required <=2");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] fet, input logic [31:0] sq);
`ifdef FETCH_PERF_EN
        chk({tag, "_fetched"}, perf_fetched, fet);
        chk({tag, "_squashed"}, perf_squashed, sq);
`else
        chk({tag, "_fetched"}, perf_fetched, 32'd0);
        chk({tag, "_squashed"}, perf_squashed, 32'd0);
`endif
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk_perf("rst", 32'd0, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_addr", imem_addr, 32'd0);
        step();  // edge 1: BOOT -> RUN
        chk("e1_valid", {31'd0, out_valid}, 32'd0);
        step();  // edge 2: issue RESET_PC
        chk("e2_valid", {31'd0, out_valid}, 32'd0);
        step();  // edge 3: first delivery
        chk("e3_valid", {31'd0, out_valid}, 32'd1);
        chk("e3_pc", out_pc, 32'd0);
        chk("e3_inst", out_inst, 32'hA000_0000);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("stream_pc", out_pc, 32'(i));
            chk("stream_inst", out_inst, 32'hA000_0000 | 32'(i));
        end

        // Back-pressure with head at pc 4.
        out_ready = 1'b0;
        step();
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_pc", out_pc, 32'd4);
        step();
        chk("stall_count", {30'd0, dut.count_q}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_pc", out_pc, 32'd4);
            chk("stall_hold_inst", out_inst, 32'hA000_0004);
        end
        out_ready = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            step();
            chk("release_pc", out_pc, 32'(i));
        end

        // Redirect with two buffered entries and no pop.
        out_ready = 1'b0;
        step();
        chk("pre_redir_pc", out_pc, 32'd7);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        chk_perf("redir1", 32'd7, 32'd2);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        chk("redir_tgt_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_tgt_pc", out_pc, 32'h40);
        step();
        chk("redir_tgt_pc1", out_pc, 32'h41);

        // Redirect in the same cycle as a pop, buffer full.
        out_ready = 1'b0;
        step();
        chk("full_count", {30'd0, dut.count_q}, 32'd2);
        chk("full_pc", out_pc, 32'h41);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        chk("redir_pop_valid", {31'd0, out_valid}, 32'd0);
        chk_perf("redir2", 32'd9, 32'd3);
        redirect_valid = 1'b0;
        step();
        chk("redir_pop_pc", out_pc, 32'h40);
        step();
        chk("redir_pop_pc1", out_pc, 32'h41);

        // Halt, redirect while halted, resume.
        halt_req = 1'b1;
        step();
        chk("halt1_halted", {31'd0, halted}, 32'd0);
        chk("halt1_pc", out_pc, 32'h42);
        step();
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        chk("halt2_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("halt3_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        chk("halt_redir_halted", {31'd0, halted}, 32'd1);
        chk("halt_redir_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        step();
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_addr", imem_addr, 32'h20);
        step();
        chk("resume_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("resume_pc", out_pc, 32'h20);
        chk("resume_inst", out_inst, 32'hA000_0020);
        step();
        chk("resume_pc1", out_pc, 32'h21);
        chk_perf("resume", 32'd13, 32'd3);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFE);
        step();
        chk("wrap_pc1", out_pc, 32'hFFFF_FFFF);
        step();
        chk("wrap_pc2", out_pc, 32'h0);
        chk("wrap_inst2", out_inst, 32'hA000_0000);
        step();
        chk("wrap_pc3", out_pc, 32'h1);
        chk_perf("wrap", 32'd17, 32'd4);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_inst", out_inst, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk_perf("arst", 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
